// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, persistence filter and rise/fall pulser.
// Optional per-channel saturating edge counters are built when EDGE_CNT_EN is defined.
module multi_edge_detector #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       signal_in,
  input  logic [2*CH-1:0]     edge_mode,
  output logic [CH-1:0]       pulse_out,
  output logic                any_pulse,
  output logic [CH-1:0]       level_out
`ifdef EDGE_CNT_EN
  ,
  input  logic                cnt_clr,
  output logic [CH*CNT_W-1:0] edge_cnt
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic w_s;
      logic r_level;
      logic r_prev;
      logic r_pulse;

      if (SYNC_STAGES == 0) begin : g_nosync
        assign w_s = signal_in[gi];
      end else begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_sync <= '0;
          else        r_sync <= (r_sync << 1) | SYNC_STAGES'(signal_in[gi]);
        end
        assign w_s = r_sync[SYNC_STAGES-1];
      end

      if (FILTER_LEN == 0) begin : g_nofilt
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_level <= 1'b0;
          else        r_level <= w_s;
        end
      end else begin : g_filt
        localparam int FC_W = $clog2(FILTER_LEN + 1);
        logic [FC_W-1:0] r_fc;
        // r_fc counts mismatching clocks already seen; the FILTER_LEN-th one commits the new level.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_fc    <= '0;
            r_level <= 1'b0;
          end else if (w_s == r_level) begin
            r_fc <= '0;
          end else if (r_fc == FC_W'(FILTER_LEN - 1)) begin
            r_level <= w_s;
            r_fc    <= '0;
          end else begin
            r_fc <= r_fc + FC_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prev  <= 1'b0;
          r_pulse <= 1'b0;
        end else begin
          r_prev  <= r_level;
          r_pulse <= (edge_mode[2*gi]   &  r_level & ~r_prev) |
                     (edge_mode[2*gi+1] & ~r_level &  r_prev);
        end
      end

      assign pulse_out[gi] = r_pulse;
      assign level_out[gi] = r_level;

`ifdef EDGE_CNT_EN
      logic [CNT_W-1:0] r_cnt;
      // Clear has priority over a coincident increment; the count sticks at all-ones.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       r_cnt <= '0;
        else if (cnt_clr)                                 r_cnt <= '0;
        else if (r_pulse && (r_cnt != {CNT_W{1'b1}}))     r_cnt <= r_cnt + CNT_W'(1);
      end
      assign edge_cnt[gi*CNT_W +: CNT_W] = r_cnt;
`endif
    end
  endgenerate

  assign any_pulse = |pulse_out;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: sample-window reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_multi_edge_detector;
  localparam int CH    = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int CNT_W = 4;
  localparam int EMW   = 2 * CH;
  localparam int HD    = 16;

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    signal_in;
  logic [EMW-1:0]   edge_mode;
  logic [CH-1:0]    pulse_out;
  logic             any_pulse;
  logic [CH-1:0]    level_out;
`ifdef EDGE_CNT_EN
  logic             cnt_clr;
  logic [CH*CNT_W-1:0] edge_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  multi_edge_detector #(
    .CH(CH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .signal_in (signal_in),
    .edge_mode (edge_mode),
    .pulse_out (pulse_out),
    .any_pulse (any_pulse),
    .level_out (level_out)
`ifdef EDGE_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .edge_cnt  (edge_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the filtered level flips once the last FILT synchronised
  // samples all disagree with it; a pulse reports a level change one clock later.
  logic [CH-1:0] m_raw [HD];
  logic [CH-1:0] m_s   [HD];
  logic [CH-1:0] m_lvl, m_lvl_prev, m_pulse;
`ifdef EDGE_CNT_EN
  int m_cnt [CH];
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HD; k++) begin
        m_raw[k] = '0;
        m_s[k]   = '0;
      end
      m_lvl      = '0;
      m_lvl_prev = '0;
      m_pulse    = '0;
`ifdef EDGE_CNT_EN
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
`endif
    end else begin
      logic [CH-1:0] new_pulse;
      for (int c = 0; c < CH; c++) begin
        logic rise, fall;
        rise = m_lvl[c] && !m_lvl_prev[c];
        fall = !m_lvl[c] && m_lvl_prev[c];
        new_pulse[c] = (edge_mode[2*c] && rise) || (edge_mode[2*c+1] && fall);
      end
`ifdef EDGE_CNT_EN
      for (int c = 0; c < CH; c++) begin
        if (cnt_clr) m_cnt[c] = 0;
        else if (m_pulse[c] && m_cnt[c] < (2**CNT_W) - 1) m_cnt[c] = m_cnt[c] + 1;
      end
`endif
      for (int k = HD - 1; k > 0; k--) begin
        m_raw[k] = m_raw[k-1];
        m_s[k]   = m_s[k-1];
      end
      m_raw[0]   = signal_in;
      m_s[0]     = m_raw[SYNC];
      m_lvl_prev = m_lvl;
      for (int c = 0; c < CH; c++) begin
        if (FILT == 0) begin
          m_lvl[c] = m_s[0][c];
        end else begin
          bit all_differ;
          all_differ = 1'b1;
          for (int k = 0; k < FILT; k++)
            if (m_s[k][c] == m_lvl[c]) all_differ = 1'b0;
          if (all_differ) m_lvl[c] = ~m_lvl[c];
        end
      end
      m_pulse = new_pulse;
    end
  end

  always @(negedge clk) begin
    n_vec++;
    if (pulse_out !== m_pulse || level_out !== m_lvl || any_pulse !== (|m_pulse)) begin
      n_err++;
      $display("FAIL model_cycle t=%0t: pulse=%b level=%b any=%b, expected pulse=%b level=%b any=%b",
               $time, pulse_out, level_out, any_pulse, m_pulse, m_lvl, |m_pulse);
    end
`ifdef EDGE_CNT_EN
    for (int c = 0; c < CH; c++) begin
      n_vec++;
      if (edge_cnt[c*CNT_W +: CNT_W] !== CNT_W'(m_cnt[c])) begin
        n_err++;
        $display("FAIL model_cnt ch%0d t=%0t: got %0d expected %0d",
                 c, $time, edge_cnt[c*CNT_W +: CNT_W], m_cnt[c]);
      end
    end
`endif
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n, input int ch, output int np, output int nl);
    np = 0;
    nl = 0;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (pulse_out[ch]) np++;
      if (level_out[ch]) nl++;
    end
  endtask

  initial begin
    int np, nl, tot, full, nz;
    bit found;
    int exp_cnt [4];
    exp_cnt = '{0, 2, 2, 4};

    rst_n = 1'b0; signal_in = '0; edge_mode = '0;
`ifdef EDGE_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) cyc();
    chk("reset_pulse", 64'(pulse_out), 64'h0);
    chk("reset_level", 64'(level_out), 64'h0);
    chk("reset_any",   64'(any_pulse), 64'h0);
    rst_n = 1'b1;
    repeat (3) cyc();

    // Latency: level after 6 clocks, pulse on clock 7 only.
    edge_mode = EMW'(8'h01);
    signal_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 5) chk("lat_level_c5", 64'(level_out[0]), 64'h0);
      if (k == 6) begin
        chk("lat_level_c6", 64'(level_out[0]), 64'h1);
        chk("lat_pulse_c6", 64'(pulse_out[0]), 64'h0);
      end
      if (k == 7) begin
        chk("lat_pulse_c7", 64'(pulse_out[0]), 64'h1);
        chk("lat_any_c7",   64'(any_pulse),    64'h1);
      end
      if (k == 8) chk("lat_pulse_c8", 64'(pulse_out[0]), 64'h0);
    end
    $display("txn latency ch0: level at clk 6, pulse at clk 7");

    // Glitch rejection at FILT-1, acceptance at FILT.
    edge_mode[3:2] = 2'b11;
    signal_in[1] = 1'b1; run(3, 1, np, nl); tot = np;
    signal_in[1] = 1'b0; run(12, 1, np, nl); tot += np;
    chk("glitch3_pulses", 64'(tot), 64'h0);
    chk("glitch3_level",  64'(nl),  64'h0);
    signal_in[1] = 1'b1; run(4, 1, np, nl); tot = np;
    signal_in[1] = 1'b0; run(16, 1, np, nl); tot += np;
    chk("glitch4_pulses", 64'(tot), 64'h2);
    $display("txn glitch ch1: 3-clk pulse rejected, 4-clk pulse accepted");

    // Mode sweep on ch2: two full toggles per mode.
    for (int m = 0; m < 4; m++) begin
      edge_mode[5:4] = 2'(m);
      tot = 0;
      for (int r = 0; r < 2; r++) begin
        signal_in[2] = 1'b1; run(8, 2, np, nl); tot += np;
        signal_in[2] = 1'b0; run(8, 2, np, nl); tot += np;
      end
      chk($sformatf("mode%0d_pulses", m), 64'(tot), 64'(exp_cnt[m]));
      $display("txn mode %0d ch2: %0d pulses", m, tot);
    end
    signal_in[2] = 1'b1; run(10, 2, np, nl);
    tot = 0;
    for (int m = 0; m < 4; m++) begin
      edge_mode[5:4] = 2'(m);
      run(3, 2, np, nl); tot += np;
    end
    chk("mode_switch_static", 64'(tot), 64'h0);

    // Simultaneous rise on every channel.
    signal_in = '0; run(10, 0, np, nl);
    edge_mode = EMW'(8'h55);
    signal_in = '1;
    full = 0; nz = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (pulse_out == '1) full++;
      if (pulse_out != '0) nz++;
    end
    chk("simul_full", 64'(full), 64'h1);
    chk("simul_nonzero", 64'(nz), 64'h1);
    signal_in = '0; run(10, 0, np, nl);
    $display("txn simultaneous rise: all channels pulsed together");

    // Reset mid-filter, then input held high through release.
    edge_mode = EMW'(8'h03);
    signal_in[0] = 1'b1;
    repeat (4) cyc();
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_filter", 64'({pulse_out, level_out, any_pulse}), 64'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    run(12, 0, np, nl);
    chk("rst_release_pulses", 64'(np), 64'h1);
    // Reset landing on a live pulse.
    signal_in[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc();
      if (pulse_out[0]) found = 1'b1;
    end
    chk("rst_pulse_seen", 64'(found), 64'h1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_pulse", 64'({pulse_out, level_out, any_pulse}), 64'h0);
    cyc();
    rst_n = 1'b1;
    run(10, 0, np, nl);
    chk("rst_after_pulse", 64'(np), 64'h0);
    $display("txn reset: mid-filter and mid-pulse");

`ifdef EDGE_CNT_EN
    edge_mode = EMW'(8'h01);
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0; cyc();
    chk("cnt_cleared", 64'(edge_cnt[CNT_W-1:0]), 64'h0);
    for (int r = 0; r < 20; r++) begin
      signal_in[0] = 1'b1; run(8, 0, np, nl);
      signal_in[0] = 1'b0; run(8, 0, np, nl);
    end
    chk("cnt_saturated", 64'(edge_cnt[CNT_W-1:0]), 64'hF);
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    for (int r = 0; r < 2; r++) begin
      signal_in[0] = 1'b1; run(8, 0, np, nl);
      signal_in[0] = 1'b0; run(8, 0, np, nl);
    end
    chk("cnt_two", 64'(edge_cnt[CNT_W-1:0]), 64'h2);
    signal_in[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc();
      if (pulse_out[0]) found = 1'b1;
    end
    chk("cnt_pulse_seen", 64'(found), 64'h1);
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    chk("cnt_clr_wins", 64'(edge_cnt[CNT_W-1:0]), 64'h0);
    cyc();
    chk("cnt_clr_hold", 64'(edge_cnt[CNT_W-1:0]), 64'h0);
    signal_in[0] = 1'b0; run(8, 0, np, nl);
    $display("txn counters: saturation and clear priority");
`endif

    // Randomized traffic with occasional mode changes, clears and resets.
    for (int t = 0; t < 3000; t++) begin
      int rate;
      rate = (t < 1500) ? 3 : 9;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(rate) == 0) signal_in[c] = ~signal_in[c];
      if ($urandom_range(15) == 0) edge_mode = EMW'($urandom());
`ifdef EDGE_CNT_EN
      cnt_clr = ($urandom_range(31) == 0);
`endif
      rst_n = ($urandom_range(599) != 0);
      cyc();
    end
    rst_n = 1'b1;
`ifdef EDGE_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (12) cyc();
    $display("txn random: 3000 cycles");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
